// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Samples a multiplexed, active-low 7-segment display bus (one-hot-low anode
// select plus {p,g,f,e,d,c,b,a}). Each digit that stays stable long enough is
// decoded back to a hex nibble. Once every digit has been seen, the complete
// frame is published together with a one-cycle frame_valid pulse.
module seg7_scan_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     AN,
    input  logic [7:0]            SEGMENT,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     point_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid,
    output logic                  frame_err
);

    // Counter wide enough to hold STABLE_CYC itself (the saturation value).
    localparam int CNT_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam int SMP_W = DIGITS + 8;

    // Decoded pattern packed as {err, blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b10_0000;
        case (seg)
            7'h40:   r = {2'b00, 4'h0};
            7'h79:   r = {2'b00, 4'h1};
            7'h24:   r = {2'b00, 4'h2};
            7'h30:   r = {2'b00, 4'h3};
            7'h19:   r = {2'b00, 4'h4};
            7'h12:   r = {2'b00, 4'h5};
            7'h02:   r = {2'b00, 4'h6};
            7'h78:   r = {2'b00, 4'h7};
            7'h00:   r = {2'b00, 4'h8};
            7'h10:   r = {2'b00, 4'h9};
            7'h08:   r = {2'b00, 4'hA};
            7'h03:   r = {2'b00, 4'hB};
            7'h46:   r = {2'b00, 4'hC};
            7'h21:   r = {2'b00, 4'hD};
            7'h06:   r = {2'b00, 4'hE};
            7'h0E:   r = {2'b00, 4'hF};
            7'h7F:   r = {2'b01, 4'h0};
            default: r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0]   an_m;
    logic [DIGITS-1:0]   s_an;
    logic [7:0]          seg_m;
    logic [7:0]          s_seg;
    logic [SMP_W-1:0]    prev_smp;
    logic [CNT_W-1:0]    cnt;

    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] sh_hex;
    logic [DIGITS-1:0]   sh_point;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_err;

    logic                changed;
    logic [DIGITS-1:0]   sel;
    logic                single;
    logic                capture;
    logic                all_seen;
    logic [5:0]          dec;

    // Two-flop synchronisers for the asynchronous display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m  <= '0;
            s_an  <= '0;
            seg_m <= '0;
            s_seg <= '0;
        end else begin
            an_m  <= AN;
            s_an  <= an_m;
            seg_m <= SEGMENT;
            s_seg <= seg_m;
        end
    end

    // Capture qualification: sample must be unchanged, counter about to hit
    // saturation, and exactly one anode driven.
    always_comb begin
        changed  = ({s_an, s_seg} != prev_smp);
        sel      = ~s_an;
        single   = $onehot(sel);
        capture  = !changed && (cnt == CNT_W'(STABLE_CYC - 1)) && single;
        all_seen = &seen;
        dec      = decode_seg(s_seg[6:0]);
    end

    // Stability counter: restart on any change, saturate at STABLE_CYC so a
    // long dwell yields only a single capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_smp <= '0;
            cnt      <= '0;
        end else begin
            prev_smp <= {s_an, s_seg};
            if (changed) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(STABLE_CYC)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shadow frame: last capture of each digit wins; seen clears on publish,
    // and a capture in the publish cycle starts the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen     <= '0;
            sh_hex   <= '0;
            sh_point <= '0;
            sh_blank <= '0;
            sh_err   <= '0;
        end else begin
            seen <= (all_seen ? '0 : seen) | (capture ? sel : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && sel[i]) begin
                    sh_hex[4*i +: 4] <= dec[3:0];
                    sh_blank[i]      <= dec[4];
                    sh_err[i]        <= dec[5];
                    sh_point[i]      <= ~s_seg[7];
                end
            end
        end
    end

    // Publish the completed frame; outputs hold until the next publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out     <= '0;
            point_out   <= '0;
            blank_out   <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= all_seen;
            if (all_seen) begin
                hex_out   <= sh_hex;
                point_out <= sh_point;
                blank_out <= sh_blank;
                err_out   <= sh_err;
                frame_err <= |sh_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (DIGITS=4, STABLE_CYC=4).
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] hex_out;
    logic [3:0]  point_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;
    logic        frame_valid;
    logic        frame_err;

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .AN          (AN),
        .SEGMENT     (SEGMENT),
        .hex_out     (hex_out),
        .point_out   (point_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Frame monitor: counts pulses, records published hex, and flags any
    // output change that is not accompanied by frame_valid.
    int          pulses = 0;
    int          hold_viol = 0;
    logic [15:0] cap_hex [16];
    logic [27:0] prev_out = '0;

    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            cap_hex[pulses % 16] = hex_out;
            pulses = pulses + 1;
        end
        if (rst_n && !frame_valid &&
            ({hex_out, point_out, blank_out, err_out} != prev_out))
            hold_viol = hold_viol + 1;
        prev_out = {hex_out, point_out, blank_out, err_out};
    end

    typedef struct {
        logic [31:0] segs;   // {d3,d2,d1,d0}
        int          dwell;
        int          frames;
        logic [15:0] hex;
        logic [3:0]  pt;
        logic [3:0]  blk;
        logic [3:0]  err;
        logic        ferr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        AN = an;
        SEGMENT = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    task automatic scan(input logic [31:0] segs, input int dwell);
        logic [3:0] an;
        for (int i = 0; i < 4; i++) begin
            an = ~(4'b0001 << i);
            drive(an, segs[8*i +: 8], dwell);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        AN = 4'hF;
        SEGMENT = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
    endtask

    int base;

    initial begin
        vecs[0] = '{32'hB0A4F9C0, 10, 1, 16'h3210, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[1] = '{32'hA1C68388, 10, 1, 16'hDCBA, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[2] = '{32'h82928E86, 10, 1, 16'h65FE, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[3] = '{32'h30247940, 10, 1, 16'h3210, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[4] = '{32'h19F80090, 10, 1, 16'h4789, 4'hA, 4'h0, 4'h0, 1'b0};
        vecs[5] = '{32'hB0A4F9C0,  4, 0, 16'h4789, 4'hA, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{32'hF9C0B0A4,  7, 1, 16'h1032, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[7] = '{32'hFEFF7F7F, 10, 1, 16'h0000, 4'h3, 4'h7, 4'h8, 1'b1};

        rst_n = 1'b0;
        AN = 4'hF;
        SEGMENT = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hex", 32'(hex_out), 32'h0);
        check("reset_flags", 32'({point_out, blank_out, err_out}), 32'h0);
        check("reset_fv", 32'({frame_valid, frame_err}), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            base = pulses;
            scan(vecs[v].segs, vecs[v].dwell);
            idle(12);
            check($sformatf("v%0d_frames", v), 32'(pulses - base), 32'(vecs[v].frames));
            check($sformatf("v%0d_hex", v), 32'(hex_out), 32'(vecs[v].hex));
            check($sformatf("v%0d_point", v), 32'(point_out), 32'(vecs[v].pt));
            check($sformatf("v%0d_blank", v), 32'(blank_out), 32'(vecs[v].blk));
            check($sformatf("v%0d_err", v), 32'(err_out), 32'(vecs[v].err));
            check($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vecs[v].ferr));
        end

        // Asynchronous reset in the middle of a partial frame
        drive(4'hE, 8'hC0, 10);
        AN = 4'hD;
        SEGMENT = 8'hF9;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_hex", 32'(hex_out), 32'h0);
        check("async_rst_flags", 32'({point_out, blank_out, err_out}), 32'h0);
        check("async_rst_fv", 32'({frame_valid, frame_err}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        base = pulses;
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        idle(12);
        check("partial_discarded", 32'(pulses - base), 32'd0);

        // Segment glitch within a dwell restarts the counter
        do_reset();
        base = pulses;
        drive(4'hE, 8'h88, 3);
        drive(4'hE, 8'h80, 1);
        drive(4'hE, 8'h88, 10);
        drive(4'hD, 8'hF9, 10);
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        idle(12);
        check("glitch_frames", 32'(pulses - base), 32'd1);
        check("glitch_hex", 32'(hex_out), 32'h321A);
        check("glitch_point", 32'(point_out), 32'h0);

        // Two anodes low, then all idle: neither may capture digit 0
        do_reset();
        base = pulses;
        drive(4'hC, 8'hC0, 20);
        drive(4'hF, 8'hC0, 20);
        drive(4'hD, 8'hF9, 10);
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        idle(12);
        check("anode_fault_frames", 32'(pulses - base), 32'd0);
        drive(4'hE, 8'hC0, 10);
        idle(12);
        check("anode_fault_done", 32'(pulses - base), 32'd1);
        check("anode_fault_hex", 32'(hex_out), 32'h3210);

        // Digit 1 scanned twice in one frame: last capture wins
        do_reset();
        base = pulses;
        drive(4'hE, 8'hC0, 10);
        drive(4'hD, 8'hF9, 10);
        drive(4'hD, 8'h92, 10);
        drive(4'hB, 8'hA4, 10);
        drive(4'h7, 8'hB0, 10);
        idle(12);
        check("repeat_frames", 32'(pulses - base), 32'd1);
        check("repeat_hex", 32'(hex_out), 32'h3250);

        // Back-to-back frames with no idle gap
        do_reset();
        base = pulses;
        scan(32'hB0A4F9C0, 10);
        scan(32'hA1C68388, 10);
        idle(12);
        check("b2b_frames", 32'(pulses - base), 32'd2);
        check("b2b_first", 32'(cap_hex[base % 16]), 32'h3210);
        check("b2b_second", 32'(cap_hex[(base + 1) % 16]), 32'hDCBA);

        check("outputs_hold", 32'(hold_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
